// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path.
// Holds the arbiter state encoding and the default byte width.
package uart_pkg;

  localparam int DEF_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RISE,
    WAIT_FALL
  } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Rotate-and-find-first selector for round-robin arbitration.
// Purely combinational; picks the first valid at or after ptr.
module rr_priority_select #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  sel,
  output logic          any_set
);

  always_comb begin
    sel     = '0;
    any_set = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!any_set && valid[idx]) begin
        sel[idx] = 1'b1;
        any_set  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte streams.
// Grants are frame-locked until last byte or the burst limit.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int MAX_BURST    = 16,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           grant,
  output logic                       tx_start,
  output logic [DATA_BITS-1:0]       tx_data,
  input  logic                       tx_busy,
  output logic                       timeout_err
);

  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [TW-1:0] TO_LAST   = TW'(BUSY_TIMEOUT - 1);
  localparam logic [PW-1:0] IDX_LAST  = PW'(N_REQ - 1);

  arb_state_t state;

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        g_idx;
  logic [BW-1:0]        burst_cnt;
  logic [TW-1:0]        to_cnt;
  logic                 last_q;

  logic [N_REQ-1:0]     sel;
  logic                 sel_any;
  logic [PW-1:0]        sel_idx;
  logic [DATA_BITS-1:0] g_data;
  logic                 g_valid;
  logic                 g_last;
  logic                 hs;

  rr_priority_select #(
    .N  (N_REQ),
    .PW (PW)
  ) u_sel (
    .valid   (req_valid),
    .ptr     (rr_ptr),
    .sel     (sel),
    .any_set (sel_any)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel[i]) sel_idx = PW'(i);
    end
  end

  assign g_valid   = req_valid[g_idx];
  assign g_last    = req_last[g_idx];
  assign g_data    = req_data[g_idx*DATA_BITS +: DATA_BITS];
  assign hs        = (state == SEND) && g_valid && !tx_busy;
  assign req_ready = hs ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      g_idx       <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      to_cnt      <= '0;
      last_q      <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_any) begin
            grant     <= sel;
            g_idx     <= sel_idx;
            burst_cnt <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            tx_data  <= g_data;
            last_q   <= g_last;
            tx_start <= 1'b1;
            to_cnt   <= '0;
            if (burst_cnt != BURST_MAX)
              burst_cnt <= burst_cnt + 1'b1;
            state    <= WAIT_RISE;
          end
        end
        WAIT_RISE: begin
          if (tx_busy) begin
            state <= WAIT_FALL;
          end else if (to_cnt == TO_LAST) begin
            // busy never came; treat the byte as done
            timeout_err <= 1'b1;
            state       <= WAIT_FALL;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_FALL: begin
          if (!tx_busy) begin
            if (last_q || burst_cnt == BURST_MAX) begin
              grant  <= '0;
              rr_ptr <= (g_idx == IDX_LAST) ? '0 : g_idx + 1'b1;
              state  <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
